// File: rtl/frog_death_monitor.sv
// Per-frame frog hazard monitor: decides deaths, sequences the death animation,
// the respawn and the post-respawn grace period. Build with FROG_TIMEOUT_EN to get the per-life timer.
module frog_death_monitor #(
  parameter int RIVER_Y_TOP  = 80,
  parameter int RIVER_Y_BOT  = 200,
  parameter int X_MAX        = 600,
  parameter int DEATH_FRAMES = 32,
  parameter int GRACE_FRAMES = 60,
  parameter int TIME_LIMIT   = 1800
) (
  input  logic        frame_clk,
  input  logic        game_restart_n,
  input  logic [10:0] frog_x,
  input  logic [10:0] frog_y,
  input  logic        car_hit,
  input  logic        on_log,
  input  logic        frog_home,
  input  logic        game_halt,
  output logic        dead_frog,
  output logic [1:0]  death_cause,
  output logic        frog_frozen,
  output logic [1:0]  death_anim_frame,
  output logic        frog_respawn,
  output logic        invulnerable,
  output logic [10:0] time_left
);

  typedef enum logic [1:0] {ALIVE, DYING, GRACE} state_t;
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_CAR     = 2'd1,
    CAUSE_WATER   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_t;

  localparam logic [7:0]  DYING_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0]  GRACE_LAST  = 8'(GRACE_FRAMES - 1);
  localparam logic [7:0]  ANIM_STEP   = 8'(DEATH_FRAMES / 4);
  localparam logic [10:0] TIME_RELOAD = 11'(TIME_LIMIT);

  state_t      state, state_d;
  logic [7:0]  frame_cnt, frame_cnt_d;
  cause_t      cause_q, cause_d;
  logic        dead_d, respawn_d;
  logic [7:0]  anim_idx;
  logic [1:0]  anim_d;

  logic        in_river, off_screen;
  logic        hit_car, hit_water, hit_timeout;

  assign in_river   = (frog_y >= 11'(RIVER_Y_TOP)) && (frog_y <= 11'(RIVER_Y_BOT));
  assign off_screen = frog_x > 11'(X_MAX);
  assign hit_car    = car_hit;
  assign hit_water  = (in_river && !on_log) || off_screen;

`ifdef FROG_TIMEOUT_EN
  logic [10:0] time_q, time_d;

  assign hit_timeout = (time_q == 11'd0);
  assign time_left   = time_q;

  // Respawn and home reloads win over the decrement; DYING ignores frog_home.
  always_comb begin
    time_d = time_q;
    if (state == DYING) begin
      if (respawn_d) time_d = TIME_RELOAD;
    end else if (frog_home) begin
      time_d = TIME_RELOAD;
    end else if (state == ALIVE && !game_halt && time_q != 11'd0) begin
      time_d = time_q - 11'd1;
    end
  end

  always_ff @(posedge frame_clk or negedge game_restart_n) begin
    if (!game_restart_n) time_q <= TIME_RELOAD;
    else                 time_q <= time_d;
  end
`else
  logic unused_frog_home;

  assign hit_timeout      = 1'b0;
  assign time_left        = 11'd0;
  assign unused_frog_home = frog_home;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state;
    frame_cnt_d = frame_cnt;
    cause_d     = cause_q;
    dead_d      = 1'b0;
    respawn_d   = 1'b0;

    case (state)
      ALIVE: begin
        if (!game_halt && (hit_car || hit_water || hit_timeout)) begin
          state_d     = DYING;
          frame_cnt_d = 8'd0;
          dead_d      = 1'b1;
          if (hit_car)        cause_d = CAUSE_CAR;
          else if (hit_water) cause_d = CAUSE_WATER;
          else                cause_d = CAUSE_TIMEOUT;
        end
      end
      DYING: begin
        if (frame_cnt == DYING_LAST) begin
          state_d     = GRACE;
          frame_cnt_d = 8'd0;
          respawn_d   = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt + 8'd1;
        end
      end
      GRACE: begin
        if (frame_cnt == GRACE_LAST) begin
          state_d     = ALIVE;
          frame_cnt_d = 8'd0;
        end else begin
          frame_cnt_d = frame_cnt + 8'd1;
        end
      end
      default: begin
        state_d     = ALIVE;
        frame_cnt_d = 8'd0;
      end
    endcase

    // Four equal animation phases across the death sequence.
    anim_idx = frame_cnt_d / ANIM_STEP;
    anim_d   = (state_d == DYING) ? anim_idx[1:0] : 2'd0;
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge frame_clk or negedge game_restart_n) begin
    if (!game_restart_n) begin
      state            <= ALIVE;
      frame_cnt        <= 8'd0;
      cause_q          <= CAUSE_NONE;
      dead_frog        <= 1'b0;
      frog_respawn     <= 1'b0;
      frog_frozen      <= 1'b0;
      invulnerable     <= 1'b0;
      death_anim_frame <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state            <= state_d;
      frame_cnt        <= frame_cnt_d;
      cause_q          <= cause_d;
      dead_frog        <= dead_d;
      frog_respawn     <= respawn_d;
      frog_frozen      <= (state_d == DYING);
      invulnerable     <= (state_d == GRACE);
      death_anim_frame <= anim_d;
    end
  end

  assign death_cause = cause_q;

endmodule

// File: tb/tb_frog_death_monitor.sv
// Directed self-checking bench for frog_death_monitor; expectations adapt to FROG_TIMEOUT_EN.
module tb_frog_death_monitor;

  logic        frame_clk = 1'b0;
  logic        game_restart_n = 1'b0;
  logic [10:0] frog_x = '0;
  logic [10:0] frog_y = '0;
  logic        car_hit = 1'b0;
  logic        on_log = 1'b0;
  logic        frog_home = 1'b0;
  logic        game_halt = 1'b0;
  logic        dead_frog;
  logic [1:0]  death_cause;
  logic        frog_frozen;
  logic [1:0]  death_anim_frame;
  logic        frog_respawn;
  logic        invulnerable;
  logic [10:0] time_left;

`ifdef FROG_TIMEOUT_EN
  localparam int TL_RESET = 1800;
`else
  localparam int TL_RESET = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  frog_death_monitor dut (
    .frame_clk        (frame_clk),
    .game_restart_n   (game_restart_n),
    .frog_x           (frog_x),
    .frog_y           (frog_y),
    .car_hit          (car_hit),
    .on_log           (on_log),
    .frog_home        (frog_home),
    .game_halt        (game_halt),
    .dead_frog        (dead_frog),
    .death_cause      (death_cause),
    .frog_frozen      (frog_frozen),
    .death_anim_frame (death_anim_frame),
    .frog_respawn     (frog_respawn),
    .invulnerable     (invulnerable),
    .time_left        (time_left)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge frame_clk);
  endtask

  task automatic idle_inputs();
    frog_x = 11'd0; frog_y = 11'd0; car_hit = 1'b0; on_log = 1'b0;
    frog_home = 1'b0; game_halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge frame_clk);
    game_restart_n = 1'b0;
    step(2);
    game_restart_n = 1'b1;
  endtask

  task automatic wait_alive();
    int k;
    k = 0;
    while ((frog_frozen || invulnerable) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) check("wait_alive_budget", 0, 1);
  endtask

  // Drive one frame of hazard stimulus, then expect a death with the given cause.
  task automatic expect_death(input string tag, input int cause);
    step();
    idle_inputs();
    check({tag, "_dead"}, dead_frog, 1);
    check({tag, "_cause"}, death_cause, cause);
    step();
    check({tag, "_pulse_end"}, dead_frog, 0);
    wait_alive();
  endtask

  // Drive hazard-free stimulus for a few frames and expect no death.
  task automatic expect_alive(input string tag);
    int deaths;
    deaths = 0;
    repeat (3) begin
      step();
      if (dead_frog || frog_frozen) deaths++;
    end
    idle_inputs();
    check(tag, deaths, 0);
  endtask

  initial begin
    int deaths;
    int resp;
    int hit_at;

    // Reset values
    step(2);
    check("rst_dead", dead_frog, 0);
    check("rst_cause", death_cause, 0);
    check("rst_frozen", frog_frozen, 0);
    check("rst_anim", death_anim_frame, 0);
    check("rst_respawn", frog_respawn, 0);
    check("rst_invuln", invulnerable, 0);
    check("rst_time_left", time_left, TL_RESET);
    game_restart_n = 1'b1;

    // Car hit at frame 10: full death, animation, respawn and grace sequence
    step(9);
    check("pre_hit_dead", dead_frog, 0);
    car_hit = 1'b1;
    step();
    car_hit = 1'b0;
    check("car_dead", dead_frog, 1);
    check("car_cause", death_cause, 1);
    check("car_frozen", frog_frozen, 1);
    check("car_anim_k0", death_anim_frame, 0);
    for (int k = 1; k < 32; k++) begin
      step();
      check($sformatf("car_anim_k%0d", k), death_anim_frame, k / 8);
      if (k == 1) check("car_dead_once", dead_frog, 0);
    end
    check("car_frozen_end", frog_frozen, 1);
    check("car_respawn_early", frog_respawn, 0);
    step();
    check("car_respawn", frog_respawn, 1);
    check("car_unfrozen", frog_frozen, 0);
    check("car_invuln", invulnerable, 1);
    check("car_anim_off", death_anim_frame, 0);
    check("reload_time_left", time_left, TL_RESET);
    step();
    check("car_respawn_once", frog_respawn, 0);
    step(58);
    check("grace_last_frame", invulnerable, 1);
    check("grace_time_frozen", time_left, TL_RESET);
    step();
    check("grace_over", invulnerable, 0);
    check("cause_held", death_cause, 1);

    // Water and off-screen cases with river-band and X boundaries
    frog_y = 11'd120; on_log = 1'b0;
    expect_death("water_river", 2);
    frog_y = 11'd120; on_log = 1'b1; frog_x = 11'd601;
    expect_death("water_offscreen", 2);
    frog_y = 11'd120; on_log = 1'b1; frog_x = 11'd600;
    expect_alive("x_max_edge_alive");
    frog_y = 11'd79; on_log = 1'b0;
    expect_alive("river_above_alive");
    frog_y = 11'd201; on_log = 1'b0;
    expect_alive("river_below_alive");
    frog_y = 11'd200; on_log = 1'b0;
    expect_death("river_bottom_row", 2);
    frog_y = 11'd80; on_log = 1'b0;
    expect_death("river_top_row", 2);

    // game_halt masks detection but a running death sequence still completes
    game_halt = 1'b1; car_hit = 1'b1; frog_y = 11'd120;
    expect_alive("halt_masks");
    car_hit = 1'b1;
    step();
    car_hit = 1'b0;
    game_halt = 1'b1;
    check("halt_seq_dead", dead_frog, 1);
    step(31);
    check("halt_seq_frozen", frog_frozen, 1);
    step();
    check("halt_seq_respawn", frog_respawn, 1);
    game_halt = 1'b0;
    wait_alive();

    // Car, water and (with the timer) time_left = 0 in the same frame: car wins
`ifdef FROG_TIMEOUT_EN
    hit_at = 0;
    while (time_left != 11'd0 && hit_at < 2000) begin
      step();
      hit_at++;
    end
    check("combo_time_zero", time_left, 0);
`endif
    car_hit = 1'b1; frog_y = 11'd120; on_log = 1'b0;
    expect_death("combo_priority", 1);

    // car_hit held through DYING and GRACE: next death only after grace ends
    car_hit = 1'b1;
    step();
    check("hold_dead", dead_frog, 1);
    step(32);
    check("hold_respawn", frog_respawn, 1);
    deaths = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (dead_frog) deaths++;
      if (i == 59) check("hold_invuln_59", invulnerable, 1);
      if (i == 60) check("hold_invuln_60", invulnerable, 0);
    end
    check("hold_no_death_in_grace", deaths, 0);
    step();
    check("hold_dead_after_grace", dead_frog, 1);
    car_hit = 1'b0;
    wait_alive();

    // Reset asserted at frame 20 of DYING
    car_hit = 1'b1;
    step();
    car_hit = 1'b0;
    step(20);
    check("mid_dying_frozen", frog_frozen, 1);
    game_restart_n = 1'b0;
    #1;
    check("mid_rst_frozen", frog_frozen, 0);
    check("mid_rst_cause", death_cause, 0);
    check("mid_rst_anim", death_anim_frame, 0);
    check("mid_rst_invuln", invulnerable, 0);
    check("mid_rst_time_left", time_left, TL_RESET);
    step(2);
    game_restart_n = 1'b1;
    resp = 0;
    repeat (40) begin
      step();
      if (frog_respawn || invulnerable) resp++;
    end
    check("mid_rst_no_respawn", resp, 0);

`ifdef FROG_TIMEOUT_EN
    // Idle timeout and frog_home postponing it
    do_reset();
    hit_at = 0;
    for (int n = 1; n <= 2000 && hit_at == 0; n++) begin
      step();
      if (dead_frog) hit_at = n;
    end
    check("timeout_frame", hit_at, 1801);
    check("timeout_cause", death_cause, 3);

    do_reset();
    step(999);
    frog_home = 1'b1;
    step();
    frog_home = 1'b0;
    check("home_reload", time_left, 1800);
    hit_at = 0;
    for (int n = 1001; n <= 3000 && hit_at == 0; n++) begin
      step();
      if (dead_frog) hit_at = n;
    end
    check("home_timeout_frame", hit_at, 2801);
    check("home_timeout_cause", death_cause, 3);
`else
    // No timer built: long idle with a frog_home pulse never kills
    do_reset();
    frog_home = 1'b1;
    step();
    frog_home = 1'b0;
    deaths = 0;
    repeat (5000) begin
      step();
      if (dead_frog) deaths++;
    end
    check("notimer_no_death", deaths, 0);
    check("notimer_time_left", time_left, 0);
    check("notimer_cause", death_cause, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
